// File: rtl/wide_add_sequencer_pkg.sv
// wide_add_sequencer_pkg
//   Shared definitions for the wide add sequencer: FSM state encoding,
//   adder word width and the legal range of the WORDS parameter.
package wide_add_sequencer_pkg;

  localparam int WORD_W    = 16;
  localparam int WORDS_MIN = 2;
  localparam int WORDS_MAX = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // True when a WORDS value is inside the supported range.
  function automatic bit words_ok(input int w);
    return (w >= WORDS_MIN) && (w <= WORDS_MAX);
  endfunction

endpackage

// File: rtl/wide_add_sequencer_adder.sv
// carrySkipAdder16
//   16-bit carry-skip adder, four 4-bit ripple blocks. A block whose bits
//   all propagate passes its carry-in straight to the next block.
//   Ports: a, b (16) operands; cin carry in; sum (16); cout carry out.
module carrySkipAdder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  always_comb begin
    logic c, bc;
    c   = cin;
    bc  = 1'b0;
    sum = '0;
    for (int g = 0; g < 4; g++) begin
      bc = c;
      for (int i = 0; i < 4; i++) begin
        sum[4*g+i] = a[4*g+i] ^ b[4*g+i] ^ bc;
        bc = (a[4*g+i] & b[4*g+i]) | ((a[4*g+i] ^ b[4*g+i]) & bc);
      end
      // skip path: full-propagate block forwards its incoming carry
      c = (&(a[4*g +: 4] ^ b[4*g +: 4])) ? c : bc;
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//   Multi-precision adder that time-shares one carrySkipAdder16 between two
//   valid/ready requesters (round-robin). Words are added LSW first, one per
//   cycle, with the carry chained through a register.
//   Optional subtract support: define WIDE_ADD_SUB_EN.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     reqN_valid/ready            request handshake, N = 0,1
//     reqN_a, reqN_b (W)          operands, W = 16*WORDS
//     reqN_cin, reqN_sub          carry-in, subtract request
//     rsp_valid/ready             response handshake
//     rsp_sum (W), rsp_cout       result and carry out of the top word
//     rsp_id                      requester that issued the result
//     busy                        high whenever the FSM is not IDLE
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [WORD_W*WORDS-1:0] req0_a,
  input  logic [WORD_W*WORDS-1:0] req0_b,
  input  logic                  req0_cin,
  input  logic                  req0_sub,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [WORD_W*WORDS-1:0] req1_a,
  input  logic [WORD_W*WORDS-1:0] req1_b,
  input  logic                  req1_cin,
  input  logic                  req1_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WORD_W*WORDS-1:0] rsp_sum,
  output logic                  rsp_cout,
  output logic                  rsp_id,
  output logic                  busy
);

  localparam int KW = $clog2(WORDS);

  state_t                         state;
  logic [WORDS-1:0][WORD_W-1:0]   a_r, b_r, sum_r;
  logic [KW-1:0]                  k;
  logic                           carry, last_grant;
  logic                           gnt0, gnt1, sel, accept;
  logic [WORD_W*WORDS-1:0]        acc_a, acc_b;
  logic                           acc_cin;
  logic [WORD_W-1:0]              add_b, add_s;
  logic                           add_co;

  // On a tie the port not granted last wins; gnt0/gnt1 are exclusive.
  assign gnt0       = req0_valid & (~req1_valid | last_grant);
  assign gnt1       = req1_valid & (~req0_valid | ~last_grant);
  assign req0_ready = ~rst & (state == IDLE) & gnt0;
  assign req1_ready = ~rst & (state == IDLE) & gnt1;
  assign accept     = req0_ready | req1_ready;
  assign sel        = req1_ready;

  assign acc_a = sel ? req1_a : req0_a;
  assign acc_b = sel ? req1_b : req0_b;

`ifdef WIDE_ADD_SUB_EN
  logic sub_r, acc_sub;
  assign acc_sub = sel ? req1_sub : req0_sub;
  // a - b = a + ~b + 1: the requested carry-in is replaced by 1
  assign acc_cin = acc_sub | (sel ? req1_cin : req0_cin);
  assign add_b   = sub_r ? ~b_r[k] : b_r[k];

  always_ff @(posedge clk or posedge rst)
    if (rst)                         sub_r <= 1'b0;
    else if (state == IDLE && accept) sub_r <= acc_sub;
`else
  logic unused_sub;
  assign unused_sub = req0_sub | req1_sub;
  assign acc_cin    = sel ? req1_cin : req0_cin;
  assign add_b      = b_r[k];
`endif

  carrySkipAdder16 u_add (
    .a    (a_r[k]),
    .b    (add_b),
    .cin  (carry),
    .sum  (add_s),
    .cout (add_co)
  );

  assign rsp_sum = sum_r;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      sum_r      <= '0;
      k          <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_r        <= acc_a;
          b_r        <= acc_b;
          carry      <= acc_cin;
          rsp_id     <= sel;
          last_grant <= sel;
          k          <= '0;
          busy       <= 1'b1;
          state      <= CALC;
        end
        CALC: begin
          sum_r[k] <= add_s;
          carry    <= add_co;
          k        <= k + KW'(1);
          if (k == KW'(WORDS-1)) begin
            rsp_cout  <= add_co;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb_wide_add_sequencer
//   Directed bench for wide_add_sequencer (WORDS=4). Accepted requests push
//   an arithmetic model result onto a scoreboard; response handshakes pop
//   and compare it. Honors WIDE_ADD_SUB_EN for the subtract expectations.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 16*WORDS;
`ifdef WIDE_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 0, req0_sub = 0, req1_cin = 0, req1_sub = 0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_cout, rsp_id, busy;
  logic [W-1:0] rsp_sum;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
  } exp_t;

  exp_t sbq[$];
  int   id_log[$];
  int   n_vec = 0, n_bad = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sub);
    if (SUB_EN && sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  // scoreboard: push at accept, pop at response handshake
  logic [W:0] r_mon;
  exp_t       e_mon;
  always @(negedge clk) if (!rst) begin
    chk("ready_excl", (W+1)'(req0_ready & req1_ready), '0);
    if (req0_valid && req0_ready) begin
      r_mon = model(req0_a, req0_b, req0_cin, req0_sub);
      e_mon.sum = r_mon[W-1:0]; e_mon.cout = r_mon[W]; e_mon.id = 1'b0;
      sbq.push_back(e_mon); id_log.push_back(0);
    end
    if (req1_valid && req1_ready) begin
      r_mon = model(req1_a, req1_b, req1_cin, req1_sub);
      e_mon.sum = r_mon[W-1:0]; e_mon.cout = r_mon[W]; e_mon.id = 1'b1;
      sbq.push_back(e_mon); id_log.push_back(1);
    end
    if (rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) chk("rsp_unexpected", (W+1)'(1), '0);
      else begin
        e_mon = sbq.pop_front();
        chk("sb_sum",  {1'b0, rsp_sum},     {1'b0, e_mon.sum});
        chk("sb_cout", (W+1)'(rsp_cout),    (W+1)'(e_mon.cout));
        chk("sb_id",   (W+1)'(rsp_id),      (W+1)'(e_mon.id));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    sbq.delete(); id_log.delete();
  endtask

  // returns one time unit after the accept edge
  task automatic start_req(input bit p, input logic [W-1:0] a, b, input logic cin, sub);
    int t = 0;
    @(posedge clk); #1;
    if (p) begin req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub; req1_valid = 1'b1; end
    else   begin req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub; req0_valid = 1'b1; end
    @(negedge clk);
    while (!(p ? req1_ready : req0_ready) && t < 50) begin @(negedge clk); t++; end
    chk("accept_timeout", (W+1)'(t < 50), (W+1)'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [W-1:0] es, input logic ec, ei, input int elat);
    int n = 0;
    while (n < 40) begin @(negedge clk); if (rsp_valid) break; n++; end
    if (elat >= 0) chk({tag, "_lat"}, (W+1)'(n), (W+1)'(elat));
    chk({tag, "_sum"},  {1'b0, rsp_sum},  {1'b0, es});
    chk({tag, "_cout"}, (W+1)'(rsp_cout), (W+1)'(ec));
    chk({tag, "_id"},   (W+1)'(rsp_id),   (W+1)'(ei));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || sbq.size() != 0) && t < 100) begin @(negedge clk); t++; end
    chk("idle_timeout", (W+1)'(t < 100), (W+1)'(1));
  endtask

  initial begin
    int t;
    bit bad;
    logic [W-1:0] ra, rb;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy_in", (W+1)'(busy), '0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", (W+1)'(rsp_valid), '0);
    chk("rst_sum",   {1'b0, rsp_sum},   '0);
    chk("rst_cout",  (W+1)'(rsp_cout),  '0);
    chk("rst_id",    (W+1)'(rsp_id),    '0);
    chk("rst_busy",  (W+1)'(busy),      '0);
    chk("rst_rdy",   (W+1)'({req0_ready, req1_ready}), '0);

    // word-0 carry into word 1, with latency
    start_req(0, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0);
    wait_rsp("carry1", 64'h0000_0000_0001_0000, 1'b0, 1'b0, WORDS);
    wait_idle();

    // carry through every word
    start_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
    wait_rsp("carryall", 64'h0, 1'b1, 1'b1, WORDS);
    wait_idle();

    // carry-in and random operands, checked by the scoreboard
    start_req(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
      start_req(1'(i), ra, rb, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end

    // subtract request
    start_req(0, 64'd5, 64'd7, 1'b0, 1'b1);
    if (SUB_EN) wait_rsp("sub57", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, WORDS);
    else        wait_rsp("sub57", 64'd12, 1'b0, 1'b0, WORDS);
    wait_idle();
    start_req(0, 64'd7, 64'd5, 1'b0, 1'b1);
    if (SUB_EN) wait_rsp("sub75", 64'd2, 1'b1, 1'b0, WORDS);
    else        wait_rsp("sub75", 64'd12, 1'b0, 1'b0, WORDS);
    wait_idle();

    // fair arbitration from reset: both valid continuously
    do_reset();
    @(posedge clk); #1;
    req0_a = 64'h1111_2222_3333_4444; req0_b = 64'h0101_0101_0101_0101; req0_cin = 0; req0_sub = 0;
    req1_a = 64'h8000_0000_FFFF_0000; req1_b = 64'h8000_0000_0001_0000; req1_cin = 1; req1_sub = 0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    t = 0;
    while (id_log.size() < 4 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    chk("fair_timeout", (W+1)'(t < 200), (W+1)'(1));
    wait_idle();
    for (int i = 0; i < 4; i++)
      chk("fair_order", (W+1)'(id_log.size() > i ? id_log[i] : 9), (W+1)'(i % 2));

    // response back-pressure with req1 waiting
    rsp_ready = 1'b0;
    start_req(0, 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0, 1'b0);
    req1_a = 64'h5; req1_b = 64'h6; req1_cin = 0; req1_sub = 0; req1_valid = 1'b1;
    t = 0;
    while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
    for (int i = 0; i < 3; i++) begin
      chk("bp_sum",   {1'b0, rsp_sum},       {1'b0, 64'h0011_0022_0033_0044});
      chk("bp_valid", (W+1)'(rsp_valid),     (W+1)'(1));
      chk("bp_rdy1",  (W+1)'(req1_ready),    '0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_rdy1_hs", (W+1)'(req1_ready), '0);
    @(negedge clk);
    chk("bp_rdy1_after", (W+1)'(req1_ready), (W+1)'(1));
    @(posedge clk); #1; req1_valid = 1'b0;
    wait_idle();

    // reset during CALC word 2
    start_req(1, 64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_busy",  (W+1)'(busy),      '0);
    chk("midrst_valid", (W+1)'(rsp_valid), '0);
    chk("midrst_sum",   {1'b0, rsp_sum},   '0);
    sbq.delete(); id_log.delete();
    @(posedge clk); #1; rst = 1'b0;
    bad = 1'b0;
    repeat (WORDS + 2) begin @(negedge clk); if (rsp_valid || busy) bad = 1'b1; end
    chk("midrst_no_rsp", (W+1)'(bad), '0);
    start_req(1, 64'h7FFF_FFFF_0000_FFFF, 64'h0000_0001_FFFF_0001, 1'b0, 1'b0);
    wait_rsp("postrst", 64'h8000_0001_0000_0000, 1'b0, 1'b1, WORDS);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
